// File: rtl/mtimer_if.sv
// Pipeline data-bus bundle between the core (master) and a memory-mapped peripheral (slave).
interface mtimer_if;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_write,
    output mem_wmask,
    output mem_wdata,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_write,
    input  mem_wmask,
    input  mem_wdata,
    input  mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) on the Pipeline data bus with registered read data and irq.
// Optional macro MTIMER_LATCH_EN: low-word read of mtime latches the high word for tear-free 64-bit reads.
module mtimer #(
  parameter logic [31:0] BASE_ADDR = 32'h4400_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic     clk,
  input  logic     rstn,
  mtimer_if.slave  bus,
  output logic     irq_timer
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 64;
  localparam int unsigned PW   = 16;
  localparam int unsigned OW   = 16;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
  localparam logic [OW-1:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [OW-1:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [OW-1:0] OFF_TIME_LO = 16'hbff8;
  localparam logic [OW-1:0] OFF_TIME_HI = 16'hbffc;

  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   mtime_q, mtime_d;
  logic [TW-1:0]   mtimecmp_q, mtimecmp_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            irq_q, irq_d;
`ifdef MTIMER_LATCH_EN
  logic [XLEN-1:0] shadow_q, shadow_d;
`endif

  logic            tick;
  logic [TW-1:0]   mtime_next;
  logic            decoded;
  logic            wr_en;
  logic            rd_en;
  logic [OW-1:0]   offset;

  // Byte-lane merge: enabled lanes take the bus data, others keep the base word.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] base_w,
                                                  input logic [XLEN-1:0] new_w,
                                                  input logic [3:0]      mask);
    logic [XLEN-1:0] res;
    res = base_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign decoded = bus.mem_valid && (bus.mem_addr[31:16] == BASE_ADDR[31:16]);
  assign wr_en   = decoded && bus.mem_write;
  assign rd_en   = decoded && !bus.mem_write;
  assign offset  = bus.mem_addr[OW-1:0];

  always_comb begin
    presc_d    = presc_q + PW'(1);
    tick       = 1'b0;
    mtime_d    = '0;
    mtimecmp_d = mtimecmp_q;
    rdata_d    = rdata_q;
    irq_d      = (mtime_q >= mtimecmp_q);
`ifdef MTIMER_LATCH_EN
    shadow_d   = shadow_q;
`endif

    if (presc_q == PRESC_LAST) begin
      tick    = 1'b1;
      presc_d = '0;
    end

    // Tick carry lives in mtime_next; a low-word write never adds a carry of its own.
    mtime_next = mtime_q + TW'(tick);
    mtime_d    = mtime_next;

    if (wr_en) begin
      case (offset)
        OFF_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  bus.mem_wdata, bus.mem_wmask);
        OFF_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.mem_wdata, bus.mem_wmask);
        OFF_TIME_LO: mtime_d[31:0]     = merge_bytes(mtime_next[31:0],  bus.mem_wdata, bus.mem_wmask);
        OFF_TIME_HI: mtime_d[63:32]    = merge_bytes(mtime_next[63:32], bus.mem_wdata, bus.mem_wmask);
        default: ;
      endcase
    end

    // Read data reflects register values before this edge's update.
    if (rd_en) begin
      case (offset)
        OFF_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        OFF_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        OFF_TIME_LO: begin
          rdata_d  = mtime_q[31:0];
`ifdef MTIMER_LATCH_EN
          shadow_d = mtime_q[63:32];
`endif
        end
`ifdef MTIMER_LATCH_EN
        OFF_TIME_HI: rdata_d = shadow_q;
`else
        OFF_TIME_HI: rdata_d = mtime_q[63:32];
`endif
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
`ifdef MTIMER_LATCH_EN
      shadow_q   <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
`ifdef MTIMER_LATCH_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign irq_timer     = irq_q;

endmodule
